atwd_buffer_ctrl: RTL and testbench
===================================

Name: atwd_buffer_ctrl

Overview:
Sequencer for the 512x16 ATWD sample buffer RAM, which has a single clock, one write port and one read port.
- Fill phase: accepts digitized ATWD samples for 1..4 channels of 128 samples each and writes them at address {channel, sample}.
- Drain phase: reads the RAM back in address order and presents the words on a valid/ready stream toward the compression/LBM path.
- Owns every RAM address and write-enable line.

Parameters:
DATA_W, 16, sample/RAM word width
SAMPLES, 128, samples per channel (power of 2)
CHANNELS, 4, maximum channels per capture
ADDR_W, 9, RAM address width = log2(SAMPLES*CHANNELS)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
wr_start  in  1  begin a capture; honoured only in IDLE
nch  in  3  channels to capture, sampled on accepted wr_start
wr_valid  in  1  digitizer sample strobe
wr_data  in  DATA_W  digitizer sample
abort  in  1  synchronous abandon of the current capture or drain
buf_data  out  DATA_W  RAM write data
buf_wraddress  out  ADDR_W  RAM write address
buf_wren  out  1  RAM write enable
buf_rdaddress  out  ADDR_W  RAM read address
buf_q  in  DATA_W  RAM read data; valid the cycle after buf_rdaddress is presented
rd_valid  out  1  output word valid
rd_data  out  DATA_W  output word
rd_ch  out  2  channel of rd_data
rd_last  out  1  marks the final word of the capture
rd_ready  in  1  downstream accept
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the last word is accepted
wr_err  out  1  sticky flag: wr_valid seen outside FILL; cleared by wr_start

Behaviour:
- Reset: all outputs 0; state IDLE; pointers 0; output FIFO empty.
- nch latching: on accepted wr_start, nch is latched. Values 0 or >4 are treated as 4. Word limit N = nch_eff*SAMPLES.
- IDLE -> FILL on wr_start. wr_ptr <= 0; wr_err <= 0.
- FILL write path: each wr_valid registers buf_data = wr_data, buf_wraddress = wr_ptr, buf_wren = 1. Write reaches the RAM 1 cycle after wr_valid; wr_ptr increments.
- FILL exit: when the accepted word has wr_ptr == N-1, go to DRAIN. wr_valid in the same cycle as the FILL->DRAIN transition or later sets wr_err and is not written.
- wr_valid outside FILL: sets wr_err; buf_wren stays 0.
- DRAIN read issue: issue a read (buf_rdaddress <= rd_ptr, rd_ptr++) when rd_ptr < N and (fifo_count + inflight) < 2.
  - fifo_count: occupancy of a 2-entry output FIFO.
  - inflight: reads issued whose buf_q has not yet returned (0 or 1).
- Read capture: buf_q is captured into the FIFO one cycle after issue, tagged with ch = addr[ADDR_W-1:ADDR_W-2] and last = (addr == N-1).
- Output: rd_valid/rd_data/rd_ch/rd_last come from the FIFO head. The word is held stable while rd_valid=1 and rd_ready=0. It pops on rd_valid & rd_ready.
- Throughput: with rd_ready held high, first rd_valid appears 2 cycles after entering DRAIN; afterwards 1 word per cycle, with no bubbles.
- Drain completion: the handshake of the last word pulses done for 1 cycle and returns to IDLE. The same-cycle wr_start is ignored; a new wr_start is accepted from the next cycle.
- Simultaneous FIFO push/pop: occupancy is unchanged and order is preserved.
- abort (any state): next cycle the state is IDLE, the FIFO is flushed, rd_valid = 0, buf_wren = 0, and no done pulse occurs. abort has priority over wr_start.
- RAM contents after abort are don't-care.
- RST mid-operation: same result as abort, but asynchronous, and wr_err is also cleared.
- Addressing: wr_ptr and rd_ptr are ADDR_W wide and never wrap inside a capture (N <= 512).

Test Plan:
- Full capture: nch=4, 512 wr_valid with wr_data = address, rd_ready=1. Expect 512 writes at addresses 0..511, then rd_data 0..511 at 1 word/cycle, rd_ch stepping 0,1,2,3 every 128 words, rd_last and done on word 511, busy low the next cycle.
- Partial capture: nch=2. Expect exactly 256 writes and 256 reads, rd_last on address 255, and no access above 255. Also run nch=0; it must behave as nch=4.
- Backpressure: random rd_ready (~50%) over a full capture. Expect rd_data held stable while stalled, no loss, no duplication, order 0..511, and at most 2 words outstanding.
- Illegal write: wr_valid pulse while in DRAIN. Expect wr_err=1, buf_wren stays 0, and the drain data is unaffected. A subsequent wr_start clears wr_err.
- Abort: abort at word 100 of FILL, and separately at word 300 of DRAIN. Expect IDLE next cycle, rd_valid=0, no done pulse. A new capture then completes correctly.
- Async reset: assert RST mid-DRAIN, off a clock edge. Expect all outputs 0 immediately; after release, wr_start begins a fresh capture.

Source files
------------

// File: rtl/atwd_buffer_ctrl.sv
// Sequencer for the 512x16 ATWD sample buffer: fills the RAM from the digitizer,
// then drains it in address order onto a valid/ready stream through a 2-entry FIFO.
module atwd_buffer_ctrl #(
    parameter int DATA_W   = 16,
    parameter int SAMPLES  = 128,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 9
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_start,
    input  logic [2:0]        nch,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              abort,
    output logic [DATA_W-1:0] buf_data,
    output logic [ADDR_W-1:0] buf_wraddress,
    output logic              buf_wren,
    output logic [ADDR_W-1:0] buf_rdaddress,
    input  logic [DATA_W-1:0] buf_q,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        rd_ch,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              wr_err
);

    localparam int SAMPLE_W = $clog2(SAMPLES);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

    state_t            r_state, w_next_state;
    logic [1:0]        r_last_ch;
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr, r_tag_addr, w_last_addr;
    logic              r_rd_all, r_inflight;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_ch   [2];
    logic              r_fifo_last [2];
    logic              r_head;
    logic [1:0]        r_count, w_occ;
    logic [DATA_W-1:0] r_buf_data;
    logic [ADDR_W-1:0] r_buf_wraddress;
    logic              r_buf_wren, r_wr_err;
    logic              w_start, w_wr_accept, w_fill_end, w_pop, w_issue, w_done, w_push_idx;
    logic [1:0]        w_last_ch_sel;

    assign w_last_addr   = {r_last_ch, {SAMPLE_W{1'b1}}};
    assign w_last_ch_sel = (nch == 3'd0 || nch > 3'(CHANNELS)) ? 2'(CHANNELS - 1) : 2'(nch - 3'd1);
    assign w_start       = (r_state == S_IDLE) && wr_start && !abort;
    assign w_wr_accept   = (r_state == S_FILL) && wr_valid && !abort;
    assign w_fill_end    = w_wr_accept && (r_wr_ptr == w_last_addr);

    assign rd_valid = (r_count != 2'd0);
    assign rd_data  = rd_valid ? r_fifo_data[r_head] : '0;
    assign rd_ch    = rd_valid ? r_fifo_ch[r_head]   : 2'd0;
    assign rd_last  = rd_valid && r_fifo_last[r_head];
    assign w_pop    = rd_valid && rd_ready;
    assign w_done   = (r_state == S_DRAIN) && w_pop && rd_last && !abort;

    // A slot freed by this cycle's pop may be re-issued at once; that keeps the
    // stream bubble-free while never holding more than two words in the pipe.
    assign w_occ      = r_count + {1'b0, r_inflight};
    assign w_issue    = (r_state == S_DRAIN) && !abort && !r_rd_all && ((w_occ < 2'd2) || w_pop);
    assign w_push_idx = r_head ^ r_count[0];

    assign buf_data      = r_buf_data;
    assign buf_wraddress = r_buf_wraddress;
    assign buf_wren      = r_buf_wren;
    assign buf_rdaddress = r_rd_ptr;
    assign busy          = (r_state != S_IDLE);
    assign done          = w_done;
    assign wr_err        = r_wr_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (wr_start)   w_next_state = S_FILL;
                S_FILL:  if (w_fill_end) w_next_state = S_DRAIN;
                S_DRAIN: if (w_done)     w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last_ch       <= 2'd0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_tag_addr      <= '0;
            r_rd_all        <= 1'b0;
            r_inflight      <= 1'b0;
            r_head          <= 1'b0;
            r_count         <= 2'd0;
            r_buf_data      <= '0;
            r_buf_wraddress <= '0;
            r_buf_wren      <= 1'b0;
            r_fifo_data[0]  <= '0;
            r_fifo_data[1]  <= '0;
            r_fifo_ch[0]    <= 2'd0;
            r_fifo_ch[1]    <= 2'd0;
            r_fifo_last[0]  <= 1'b0;
            r_fifo_last[1]  <= 1'b0;
        end else if (abort) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_all   <= 1'b0;
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_buf_wren <= 1'b0;
        end else begin
            r_buf_wren <= 1'b0;
            if (w_start) begin
                r_last_ch <= w_last_ch_sel;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_rd_all  <= 1'b0;
            end
            if (w_wr_accept) begin
                r_buf_data      <= wr_data;
                r_buf_wraddress <= r_wr_ptr;
                r_buf_wren      <= 1'b1;
                if (!w_fill_end) r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // The read pointer parks on the last address so nothing beyond N-1 is ever presented.
            if (w_issue) begin
                r_tag_addr <= r_rd_ptr;
                if (r_rd_ptr == w_last_addr) r_rd_all <= 1'b1;
                else                         r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_fifo_data[w_push_idx] <= buf_q;
                r_fifo_ch[w_push_idx]   <= r_tag_addr[ADDR_W-1 -: 2];
                r_fifo_last[w_push_idx] <= (r_tag_addr == w_last_addr);
            end
            if (w_pop) r_head <= ~r_head;
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                   r_wr_err <= 1'b0;
        else if (w_start)                          r_wr_err <= 1'b0;
        else if (wr_valid && (r_state != S_FILL))  r_wr_err <= 1'b1;
    end

endmodule

// File: tb/tb_atwd_buffer_ctrl.sv
// Bench for atwd_buffer_ctrl: table of whole captures plus hand-written abort,
// illegal-write and asynchronous-reset sequences against a behavioural RAM.
module tb_atwd_buffer_ctrl;

    logic        CLK = 1'b0, RST = 1'b1;
    logic        wr_start = 1'b0, wr_valid = 1'b0, abort = 1'b0, rd_ready = 1'b0;
    logic [2:0]  nch = 3'd0;
    logic [15:0] wr_data = 16'd0;
    logic [15:0] buf_data, buf_q, rd_data;
    logic [8:0]  buf_wraddress, buf_rdaddress;
    logic        buf_wren, rd_valid, rd_last, busy, done, wr_err;
    logic [1:0]  rd_ch;

    atwd_buffer_ctrl dut (
        .CLK(CLK), .RST(RST), .wr_start(wr_start), .nch(nch), .wr_valid(wr_valid),
        .wr_data(wr_data), .abort(abort), .buf_data(buf_data), .buf_wraddress(buf_wraddress),
        .buf_wren(buf_wren), .buf_rdaddress(buf_rdaddress), .buf_q(buf_q), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_ch(rd_ch), .rd_last(rd_last), .rd_ready(rd_ready),
        .busy(busy), .done(done), .wr_err(wr_err)
    );

    always #5 CLK = ~CLK;

    // Synchronous single-clock RAM: read data appears the cycle after the address.
    logic [15:0] mem [512];
    always @(posedge CLK) begin
        if (buf_wren) mem[buf_wraddress] <= buf_data;
        buf_q <= mem[buf_rdaddress];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] nch;
        bit         randReady;
        bit         illegalWr;
        int         expWords;
        int         expLastAddr;
    } vec_t;

    vec_t vecs [7];
    int   nVec = 0, nMiss = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] allOutputs();
        return {6'd0, buf_data, buf_wraddress, buf_wren, buf_rdaddress, rd_valid,
                rd_data, rd_ch, rd_last, busy, done, wr_err};
    endfunction

    logic [6:0]  mon_tag = 7'd0;
    bit          mon_on = 1'b0, mon_prev_stall = 1'b0;
    logic [15:0] mon_prev_data = 16'd0;
    int mon_n = 0, mon_wr_cnt = 0, mon_rd_cnt = 0, mon_done_cnt = 0, mon_max_rd = 0;
    int mon_first_valid_cyc = -1, mon_done_cyc = -1, mon_last_wr_cyc = 0;

    function automatic logic [15:0] expWord(input int idx);
        logic [8:0] a;
        a = idx[8:0];
        return {mon_tag, a};
    endfunction

    // Stream monitor, sampled on the falling edge away from the active edge.
    always @(negedge CLK) begin
        if (done) mon_done_cnt++;
        if (buf_wren) begin
            if (mon_on) begin
                checkOutput("wrAddr", 64'(buf_wraddress), 64'(mon_wr_cnt));
                checkOutput("wrData", 64'(buf_data), 64'(expWord(mon_wr_cnt)));
            end
            mon_wr_cnt++;
            mon_last_wr_cyc = cyc;
        end
        if (mon_on) begin
            if (busy && int'(buf_rdaddress) > mon_max_rd) mon_max_rd = int'(buf_rdaddress);
            if (rd_valid && mon_first_valid_cyc < 0) mon_first_valid_cyc = cyc;
            if (mon_prev_stall) begin
                checkOutput("holdValid", 64'(rd_valid), 64'd1);
                checkOutput("holdData", 64'(rd_data), 64'(mon_prev_data));
            end
            if (rd_valid && rd_ready) begin
                checkOutput("rdData", 64'(rd_data), 64'(expWord(mon_rd_cnt)));
                checkOutput("rdCh", 64'(rd_ch), 64'((mon_rd_cnt >> 7) & 3));
                checkOutput("rdLast", 64'(rd_last), 64'(mon_rd_cnt == mon_n - 1));
                checkOutput("doneOnLast", 64'(done), 64'(mon_rd_cnt == mon_n - 1));
                if (done) mon_done_cyc = cyc;
                mon_rd_cnt++;
            end
            mon_prev_stall = rd_valid && !rd_ready;
            mon_prev_data  = rd_data;
        end
    end

    task automatic monArm(input logic [6:0] tag, input int n, input bit on);
        mon_tag = tag; mon_n = n; mon_on = on;
        mon_wr_cnt = 0; mon_rd_cnt = 0; mon_done_cnt = 0; mon_max_rd = 0;
        mon_first_valid_cyc = -1; mon_done_cyc = -1; mon_prev_stall = 1'b0;
    endtask

    task automatic startCapture(input logic [2:0] n);
        @(posedge CLK); #1;
        wr_start = 1'b1; nch = n; rd_ready = 1'b1;
        @(posedge CLK); #1;
        wr_start = 1'b0;
    endtask

    task automatic fillWords(input logic [6:0] tag, input int count, input bit gaps);
        int i = 0;
        while (i < count) begin
            if (gaps) rd_ready = 1'($urandom_range(0, 1));
            if (gaps && $urandom_range(0, 3) == 0) begin
                wr_valid = 1'b0;
            end else begin
                wr_valid = 1'b1;
                wr_data  = {tag, i[8:0]};
                i++;
            end
            @(posedge CLK); #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input logic [6:0] tag);
        bit ok = 1'b0;
        monArm(tag, v.expWords, 1'b1);
        startCapture(v.nch);
        checkOutput("busyFill", 64'(busy), 64'd1);
        checkOutput("wrErrClr", 64'(wr_err), 64'd0);
        fillWords(tag, v.expWords, v.randReady);
        for (int k = 0; k < 4000; k++) begin
            if (mon_done_cnt != 0) begin ok = 1'b1; break; end
            rd_ready = v.randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v.illegalWr && k == 5) begin wr_valid = 1'b1; wr_data = 16'hDEAD; end
            else wr_valid = 1'b0;
            @(posedge CLK); #1;
        end
        wr_valid = 1'b0;
        checkOutput("drainDone", 64'(ok), 64'd1);
        checkOutput("busyAfterDone", 64'(busy), 64'd0);
        checkOutput("validAfterDone", 64'(rd_valid), 64'd0);
        checkOutput("wrCount", 64'(mon_wr_cnt), 64'(v.expWords));
        checkOutput("rdCount", 64'(mon_rd_cnt), 64'(v.expWords));
        checkOutput("doneCount", 64'(mon_done_cnt), 64'd1);
        checkOutput("maxRdAddr", 64'(mon_max_rd), 64'(v.expLastAddr));
        checkOutput("wrErrEnd", 64'(wr_err), 64'(v.illegalWr));
        checkOutput("firstLatency", 64'(mon_first_valid_cyc - mon_last_wr_cyc), 64'd2);
        if (!v.randReady)
            checkOutput("drainRate", 64'(mon_done_cyc - mon_first_valid_cyc), 64'(v.expWords - 1));
        mon_on = 1'b0;
    endtask

    initial begin
        bit reached;
        vecs[0] = '{3'd4, 1'b0, 1'b0, 512, 511};
        vecs[1] = '{3'd2, 1'b0, 1'b0, 256, 255};
        vecs[2] = '{3'd0, 1'b0, 1'b0, 512, 511};
        vecs[3] = '{3'd4, 1'b1, 1'b0, 512, 511};
        vecs[4] = '{3'd1, 1'b1, 1'b1, 128, 127};
        vecs[5] = '{3'd7, 1'b0, 1'b1, 512, 511};
        vecs[6] = '{3'd3, 1'b1, 1'b0, 384, 383};

        repeat (3) @(posedge CLK);
        #1 checkOutput("resetOutputs", allOutputs(), 64'd0);
        RST = 1'b0;

        // wr_valid while idle flags wr_err and never writes.
        @(posedge CLK); #1 wr_valid = 1'b1; wr_data = 16'h1234;
        @(posedge CLK); #1 wr_valid = 1'b0;
        checkOutput("idleWrErr", 64'(wr_err), 64'd1);
        checkOutput("idleNoWren", 64'(buf_wren), 64'd0);

        for (int v = 0; v < 7; v++) applyStimulus(vecs[v], 7'(v + 1));

        // Abort at word 100 of the fill.
        monArm(7'h20, 512, 1'b0);
        startCapture(3'd4);
        fillWords(7'h20, 100, 1'b0);
        wr_valid = 1'b1; wr_data = 16'hBEEF; abort = 1'b1;
        @(posedge CLK); #1;
        abort = 1'b0; wr_valid = 1'b0;
        checkOutput("abortFillBusy", 64'(busy), 64'd0);
        checkOutput("abortFillWren", 64'(buf_wren), 64'd0);
        checkOutput("abortFillValid", 64'(rd_valid), 64'd0);
        repeat (5) @(posedge CLK);
        #1;
        checkOutput("abortFillWrites", 64'(mon_wr_cnt), 64'd100);
        checkOutput("abortFillNoDone", 64'(mon_done_cnt), 64'd0);
        applyStimulus(vecs[0], 7'h21);

        // Abort after 300 words of the drain have been accepted.
        monArm(7'h22, 512, 1'b1);
        startCapture(3'd4);
        fillWords(7'h22, 512, 1'b0);
        reached = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (mon_rd_cnt >= 300) begin reached = 1'b1; break; end
            @(posedge CLK); #1;
        end
        checkOutput("abortDrainReach", 64'(reached), 64'd1);
        abort = 1'b1; rd_ready = 1'b0;
        @(posedge CLK); #1;
        abort = 1'b0;
        checkOutput("abortDrainBusy", 64'(busy), 64'd0);
        checkOutput("abortDrainValid", 64'(rd_valid), 64'd0);
        mon_on = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        checkOutput("abortDrainWords", 64'(mon_rd_cnt), 64'd300);
        checkOutput("abortDrainNoDone", 64'(mon_done_cnt), 64'd0);
        applyStimulus(vecs[1], 7'h23);

        // Asynchronous reset in the middle of a drain, after an illegal write.
        monArm(7'h24, 256, 1'b0);
        startCapture(3'd2);
        fillWords(7'h24, 256, 1'b0);
        for (int k = 0; k < 20; k++) begin
            wr_valid = (k == 3);
            @(posedge CLK); #1;
        end
        wr_valid = 1'b0;
        checkOutput("drainWrErr", 64'(wr_err), 64'd1);
        checkOutput("drainStillBusy", 64'(busy), 64'd1);
        @(posedge CLK); #3 RST = 1'b1;
        #1 checkOutput("asyncResetOutputs", allOutputs(), 64'd0);
        @(negedge CLK) RST = 1'b0;
        applyStimulus(vecs[2], 7'h25);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
